// File: rtl/stochastic_to_binary.sv
// Stochastic-to-binary converter: counts ones over a window of 2^WIDTH_BN accepted
// stream bits and reports a saturated WIDTH_BN-bit value with a one-cycle valid pulse.
module stochastic_to_binary #(
    parameter int WIDTH_BN = 4
) (
    input  logic                i_clk_s2b,
    input  logic                i_rst_s2b,
    input  logic                i_start_s2b,
    input  logic                i_stop_s2b,
    input  logic                i_sn_valid_s2b,
    input  logic                i_sn_bit_s2b,
    output logic [WIDTH_BN-1:0] o_bn_s2b,
    output logic                o_valid_s2b,
    output logic [WIDTH_BN:0]   o_len_s2b,
    output logic                o_partial_s2b,
    output logic                o_sat_s2b,
    output logic                o_busy_s2b
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [WIDTH_BN:0]   FULL_LEN = {1'b1, {WIDTH_BN{1'b0}}};
    localparam logic [WIDTH_BN-1:0] MAX_BN   = {WIDTH_BN{1'b1}};

    state_e              state_q, state_d;
    logic [WIDTH_BN:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH_BN:0]   ones_cnt_q, ones_cnt_d;
    logic [WIDTH_BN-1:0] bn_q, bn_d;
    logic [WIDTH_BN:0]   len_q, len_d;
    logic                valid_q, valid_d;
    logic                partial_q, partial_d;
    logic                sat_q, sat_d;

    logic [WIDTH_BN:0]   bit_inc;
    logic [WIDTH_BN:0]   ones_inc;
    logic                win_full;
    logic                acc_exit;

    assign bit_inc  = bit_cnt_q + {{WIDTH_BN{1'b0}}, 1'b1};
    assign ones_inc = ones_cnt_q + {{WIDTH_BN{1'b0}}, i_sn_bit_s2b};
    assign win_full = i_sn_valid_s2b && (bit_inc == FULL_LEN);
    // A stop in the same cycle as the window-completing bit still reports a full window.
    assign acc_exit = (state_q == S_ACC) && (win_full || i_stop_s2b);

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge i_clk_s2b) begin
        if (i_rst_s2b) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            ones_cnt_q <= '0;
            bn_q       <= '0;
            len_q      <= '0;
            valid_q    <= 1'b0;
            partial_q  <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            ones_cnt_q <= ones_cnt_d;
            bn_q       <= bn_d;
            len_q      <= len_d;
            valid_q    <= valid_d;
            partial_q  <= partial_d;
            sat_q      <= sat_d;
        end
    end

    // NOTE: every signal gets a default at the top of the block, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        ones_cnt_d = ones_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start_s2b) begin
                    state_d    = S_ACC;
                    bit_cnt_d  = '0;
                    ones_cnt_d = '0;
                end
            end
            S_ACC: begin
                if (i_sn_valid_s2b) begin
                    bit_cnt_d  = bit_inc;
                    ones_cnt_d = ones_inc;
                end
                if (win_full || i_stop_s2b) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (i_start_s2b) begin
                    state_d    = S_ACC;
                    bit_cnt_d  = '0;
                    ones_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Results are captured from the next-state counters on the edge that leaves ACC.
    always_comb begin
        valid_d   = acc_exit;
        bn_d      = bn_q;
        len_d     = len_q;
        partial_d = partial_q;
        sat_d     = sat_q;
        if (acc_exit) begin
            sat_d     = (ones_cnt_d == FULL_LEN);
            bn_d      = (ones_cnt_d == FULL_LEN) ? MAX_BN : ones_cnt_d[WIDTH_BN-1:0];
            len_d     = bit_cnt_d;
            partial_d = !win_full;
        end
    end

    assign o_busy_s2b    = (state_q == S_ACC);
    assign o_bn_s2b      = bn_q;
    assign o_len_s2b     = len_q;
    assign o_valid_s2b   = valid_q;
    assign o_partial_s2b = partial_q;
    assign o_sat_s2b     = sat_q;

endmodule

// File: tb/tb_stochastic_to_binary.sv
// Scoreboard bench for stochastic_to_binary: stimulus pushes expected results,
// a negedge monitor pops and compares them whenever o_valid_s2b is seen.
module tb_stochastic_to_binary;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, stop, sn_valid, sn_bit;
    logic [W-1:0] bn;
    logic         valid;
    logic [W:0]   len;
    logic         partial, sat, busy;

    stochastic_to_binary #(.WIDTH_BN(W)) dut (
        .i_clk_s2b      (clk),
        .i_rst_s2b      (rst),
        .i_start_s2b    (start),
        .i_stop_s2b     (stop),
        .i_sn_valid_s2b (sn_valid),
        .i_sn_bit_s2b   (sn_bit),
        .o_bn_s2b       (bn),
        .o_valid_s2b    (valid),
        .o_len_s2b      (len),
        .o_partial_s2b  (partial),
        .o_sat_s2b      (sat),
        .o_busy_s2b     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bn;
        int len;
        int partial;
        int sat;
        int edge_no;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) busy_cnt++;
        if (valid !== 1'b0) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 32'(valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("bn",         32'(bn),      e.bn);
                check("len",        32'(len),     e.len);
                check("partial",    32'(partial), e.partial);
                check("sat",        32'(sat),     e.sat);
                check("valid_edge", cyc,          e.edge_no);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic b, input logic s, input logic st);
        sn_valid = v;
        sn_bit   = b;
        stop     = s;
        start    = st;
        step();
    endtask

    task automatic feed16(input logic [15:0] pat);
        for (int i = 15; i >= 0; i--) drive(1'b1, pat[i], 1'b0, 1'b0);
    endtask

    task automatic push(input int b, input int l, input int p, input int s, input int e);
        exp_t x;
        x.bn = b; x.len = l; x.partial = p; x.sat = s; x.edge_no = e;
        sb_q.push_back(x);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        while (sb_q.size() != 0 && k < 40) begin
            step();
            k++;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", sb_q.size(), 32'd0);
            sb_q.delete();
        end
        step();
        step();
    endtask

    initial begin
        int st;
        logic [15:0] p1;
        logic [15:0] p2;
        rst = 1'b1; start = 1'b0; stop = 1'b0; sn_valid = 1'b0; sn_bit = 1'b0;
        repeat (3) step();
        check("rst_bn",      32'(bn),      32'd0);
        check("rst_len",     32'(len),     32'd0);
        check("rst_valid",   32'(valid),   32'd0);
        check("rst_partial", 32'(partial), 32'd0);
        check("rst_sat",     32'(sat),     32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        rst = 1'b0;
        step();

        // 16 continuous bits with 11 ones
        st = cyc + 1;
        push(11, 16, 0, 0, st + 16);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        feed16(16'b1101_1011_1011_0110);
        wait_drain();

        // all ones: clipped to 15 with sat
        st = cyc + 1;
        push(15, 16, 0, 1, st + 16);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        feed16(16'hFFFF);
        wait_drain();

        // valid every other cycle, bit=1 while invalid, 6 ones
        p1 = 16'b1010_0101_0010_0010;
        st = cyc + 1;
        push(6, 16, 0, 0, st + 32);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        busy_cnt = 0;
        for (int i = 15; i >= 0; i--) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            drive(1'b1, p1[i], 1'b0, 1'b0);
        end
        wait_drain();
        check("busy_cycles", busy_cnt, 32'd32);

        // stop and bits in IDLE are ignored
        repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b0);
        step();

        // stop with the 5th valid bit, 3 ones
        st = cyc + 1;
        push(3, 5, 1, 0, st + 5);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        wait_drain();

        // stop with zero accepted bits
        st = cyc + 1;
        push(0, 0, 1, 0, st + 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        wait_drain();

        // stop together with the 16th bit: still a full window
        p1 = 16'b1000_1000_1000_1000;
        st = cyc + 1;
        push(4, 16, 0, 0, st + 16);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 15; i >= 0; i--) drive(1'b1, p1[i], (i == 0), 1'b0);
        wait_drain();

        // reset mid-window after 7 bits: no pulse, outputs cleared
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (7) drive(1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check("mid_rst_bn",      32'(bn),      32'd0);
        check("mid_rst_len",     32'(len),     32'd0);
        check("mid_rst_valid",   32'(valid),   32'd0);
        check("mid_rst_partial", 32'(partial), 32'd0);
        check("mid_rst_busy",    32'(busy),    32'd0);
        repeat (4) step();
        st = cyc + 1;
        push(6, 16, 0, 0, st + 16);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        feed16(16'b0110_0110_0000_0110);
        wait_drain();

        // back-to-back windows: start held in DONE, stray start mid-ACC
        p1 = 16'b1110_1101_0110_0100;
        p2 = 16'b0000_1000_0000_0001;
        st = cyc + 1;
        push(9, 16, 0, 0, st + 16);
        push(2, 16, 0, 0, st + 33);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 15; i >= 0; i--) drive(1'b1, p1[i], 1'b0, (i == 8));
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        feed16(p2);
        wait_drain();

        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stochastic_to_binary.md
# stochastic_to_binary

Stochastic-to-binary converter: the receive end of the SNG bit-stream link. It counts the ones in a unipolar stochastic bit stream over a window of 2^WIDTH_BN accepted bits and returns a WIDTH_BN-bit binary value. The count is saturated, and a one-cycle valid pulse marks each result. It sits after the stochastic compute lanes, ahead of the binary accumulation/readout logic.

## Interface
- WIDTH_BN, default 4: binary output width; window length is 2^WIDTH_BN accepted bits (default 16).
- i_clk_s2b  input  1  clock; all logic on its rising edge.
- i_rst_s2b  input  1  reset; synchronous and active-high, one clock.
- i_start_s2b  input  1  begin a new window; level sampled each cycle.
- i_stop_s2b  input  1  end the current window early.
- i_sn_valid_s2b  input  1  qualifies i_sn_bit_s2b; bits are counted only when high.
- i_sn_bit_s2b  input  1  stochastic stream bit.
- o_bn_s2b  output  WIDTH_BN  converted value; held until the next result.
- o_valid_s2b  output  1  one-cycle pulse; o_bn_s2b, o_len_s2b, o_partial_s2b and o_sat_s2b are new this cycle.
- o_len_s2b  output  WIDTH_BN+1  number of bits accepted in the reported window (1..2^WIDTH_BN, or 0 on an empty stop).
- o_partial_s2b  output  1  reported window ended by i_stop_s2b before full length.
- o_sat_s2b  output  1  ones count was 2^WIDTH_BN and was clipped.
- o_busy_s2b  output  1  high while in ACC.

## Operation
- Internal registers:
  - state: IDLE, ACC, DONE.
  - ones_cnt and bit_cnt: WIDTH_BN+1 bits each.
- IDLE:
  - i_start_s2b=1: go to ACC, clear ones_cnt and bit_cnt.
  - Otherwise stay in IDLE.
  - i_stop_s2b, i_sn_valid_s2b and i_sn_bit_s2b are ignored.
- ACC, on each cycle with i_sn_valid_s2b=1:
  - bit_cnt += 1.
  - ones_cnt += i_sn_bit_s2b.
- ACC exit on a full window: when the accepted bit makes bit_cnt_next == 2^WIDTH_BN, go to DONE with partial=0.
- ACC exit on a stop: i_stop_s2b=1 goes to DONE with partial=1.
  - A valid bit in the same cycle is counted first.
  - If that bit completes the window, partial=0.
  - A stop with zero accepted bits reports o_bn=0, o_len=0, partial=1.
- i_start_s2b in ACC is ignored; the window is neither restarted nor extended.
- On the edge entering DONE, register the results:
  - o_bn_s2b = min(ones_cnt_next, 2^WIDTH_BN-1).
  - o_sat_s2b = (ones_cnt_next == 2^WIDTH_BN).
  - o_len_s2b = bit_cnt_next.
  - o_partial_s2b = the exit reason.
  - o_valid_s2b is set to 1.
- DONE lasts exactly one cycle, with o_valid_s2b=1.
  - i_start_s2b=1 in DONE: go to ACC and clear the counters (back-to-back windows).
  - Otherwise go to IDLE.
- Arithmetic: counters are unsigned WIDTH_BN+1 bits. bit_cnt never exceeds 2^WIDTH_BN, so no wrap is possible.
- Encoding: an SNG-encoded value x yields exactly x ones in 16 bits, because the final SNG bit is forced 0. The decoder therefore returns x with o_sat=0 for all x in 0..15.
- Reset, in any state:
  - state=IDLE, all counters 0.
  - o_bn=0, o_len=0, o_valid=0, o_partial=0, o_sat=0, o_busy=0.
  - A window in progress is discarded and no valid pulse is produced.

## Timing
- o_busy_s2b = (state==ACC), decoded from the state register.
- Start at edge t: ACC from cycle t+1; the first bit can be counted at edge t+1.
- Last bit or stop sampled at edge k: o_valid_s2b high in cycle k+1 only. Latency is one cycle from the final accepted bit.
- Full window with continuous valid: the start edge is t and the 16th bit is accepted at edge t+16.
  - o_valid_s2b is high in cycle t+17.
  - Back-to-back restart from DONE adds one dead cycle per window.
- Gaps in i_sn_valid_s2b stretch ACC indefinitely, with no timeout.
- All outputs are registered except o_busy_s2b.

## Test plan
- Reset, start, 16 continuous valid bits containing 11 ones -> o_valid one cycle, 17 cycles after start; o_bn=11, o_len=16, o_partial=0, o_sat=0.
- 16 valid bits, all ones -> o_bn=15, o_sat=1, o_len=16.
- 16 bits with i_sn_valid_s2b low every other cycle, 6 ones, plus i_sn_bit=1 during invalid cycles -> o_bn=6; o_busy high for 32 cycles.
- Stop asserted together with the 5th valid bit, 3 ones in total -> o_bn=3, o_len=5, o_partial=1. Stop with zero bits accepted -> o_bn=0, o_len=0, o_partial=1.
- Reset asserted after 7 accepted bits -> no o_valid; all outputs 0 next cycle. A following full window with 6 ones -> o_bn=6.
- Start held high during DONE, with windows of 9 then 2 ones -> two valid pulses 17 cycles apart, o_bn=9 then 2. An extra start pulse mid-ACC changes nothing.
